// File: rtl/prog_loader.sv
// prog_loader: pulls a framed program image from the UART RX FIFO and writes
// it into instruction memory as DATA_W-wide little-endian words.
//
// Frame: 4 length bytes (little-endian byte count L), L payload bytes, then
// one checksum byte equal to the XOR of all length and payload bytes.
//
// Ports
//   clk, rst      system clock, asynchronous active-high reset
//   progEn        level enable; low aborts and returns to IDLE
//   rxFfEmpty     RX FIFO empty flag
//   rxRdEn        FIFO pop request; rxData is valid the following cycle
//   rxData        FIFO read data
//   memWrEn       one-cycle word write strobe
//   memAddr       word address (BASE_ADDR + word index)
//   memData       packed word, lane k = k-th byte of the word
//   memBe         byte enables, one per filled lane
//   progBusy      high while receiving (LEN, DATA, CSUM)
//   progDone      frame accepted; held until progEn falls
//   progErr       length overflow or checksum mismatch; held until progEn falls
//
// state | meaning
// IDLE  | waiting for progEn; clears counters, checksum and word buffer
// LEN   | reading the 4 length bytes
// DATA  | reading payload bytes and packing words
// CSUM  | reading and comparing the checksum byte
// DONE  | frame accepted
// ERR   | overflow or checksum mismatch
module prog_loader #(
  parameter int DATA_W    = 32,
  parameter int ADDR_W    = 32,
  parameter int MEM_WORDS = 8192,
  parameter int BASE_ADDR = 0
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  progEn,
  input  logic                  rxFfEmpty,
  output logic                  rxRdEn,
  input  logic [7:0]            rxData,
  output logic                  memWrEn,
  output logic [ADDR_W-1:0]     memAddr,
  output logic [DATA_W-1:0]     memData,
  output logic [DATA_W/8-1:0]   memBe,
  output logic                  progBusy,
  output logic                  progDone,
  output logic                  progErr
);

  localparam int LANES = DATA_W / 8;
  localparam int LW    = (LANES > 1) ? $clog2(LANES) : 1;
  localparam logic [32:0] MAX_BYTES = 33'(MEM_WORDS) * 33'(LANES);

  typedef enum logic [2:0] {
    S_IDLE, S_LEN, S_DATA, S_CSUM, S_DONE, S_ERR
  } state_t;

  state_t state, state_nxt;

  logic [31:0]       req_cnt, rcv_cnt, len;
  logic [7:0]        csum;
  logic [DATA_W-1:0] wbuf;
  logic [LANES-1:0]  wbe;
  logic [LW-1:0]     byte_idx;
  logic [ADDR_W-1:0] word_idx;
  logic              rd_pend;
  logic              quota_ok;

  // A byte only counts while enabled; a byte in flight during an abort is dropped.
  logic        byte_vld;
  logic [31:0] len_full;
  logic        len_last, data_last, lane_last;

  assign byte_vld  = rd_pend & progEn;
  assign len_full  = {rxData, len[23:0]};
  assign len_last  = (rcv_cnt == 32'd3);
  assign data_last = ((rcv_cnt + 32'd1) == len);
  assign lane_last = (byte_idx == LW'(LANES - 1));

  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= S_IDLE;
    else     state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    quota_ok  = 1'b0;
    case (state)
      S_IDLE: if (progEn) state_nxt = S_LEN;
      S_LEN: begin
        quota_ok = (req_cnt < 32'd4);
        if (byte_vld && len_last) begin
          if ({1'b0, len_full} > MAX_BYTES) state_nxt = S_ERR;
          else if (len_full == 32'd0)       state_nxt = S_CSUM;
          else                              state_nxt = S_DATA;
        end
      end
      S_DATA: begin
        quota_ok = (req_cnt < len);
        if (byte_vld && data_last) state_nxt = S_CSUM;
      end
      S_CSUM: begin
        quota_ok = (req_cnt == 32'd0);
        if (byte_vld) state_nxt = (rxData == csum) ? S_DONE : S_ERR;
      end
      default: ;
    endcase
    if (!progEn) state_nxt = S_IDLE;
    rxRdEn = progEn & ~rxFfEmpty & quota_ok;
  end

  assign progBusy = (state == S_LEN) || (state == S_DATA) || (state == S_CSUM);
  assign progDone = (state == S_DONE);
  assign progErr  = (state == S_ERR);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      req_cnt  <= '0;
      rcv_cnt  <= '0;
      len      <= '0;
      csum     <= '0;
      wbuf     <= '0;
      wbe      <= '0;
      byte_idx <= '0;
      word_idx <= '0;
      rd_pend  <= 1'b0;
      memWrEn  <= 1'b0;
      memAddr  <= '0;
      memData  <= '0;
      memBe    <= '0;
    end else begin
      memWrEn <= 1'b0;
      rd_pend <= rxRdEn;
      // Request/receive counters are per-state; every transition restarts them.
      if (state_nxt != state) begin
        req_cnt <= '0;
        rcv_cnt <= '0;
      end else begin
        req_cnt <= req_cnt + 32'(rxRdEn);
        rcv_cnt <= rcv_cnt + 32'(byte_vld);
      end
      case (state)
        S_IDLE: begin
          len      <= '0;
          csum     <= '0;
          wbuf     <= '0;
          wbe      <= '0;
          byte_idx <= '0;
          word_idx <= '0;
        end
        S_LEN: if (byte_vld) begin
          len[{rcv_cnt[1:0], 3'b000} +: 8] <= rxData;
          csum <= csum ^ rxData;
        end
        S_DATA: if (byte_vld) begin
          csum <= csum ^ rxData;
          if (lane_last || data_last) begin
            memWrEn  <= 1'b1;
            memAddr  <= ADDR_W'(BASE_ADDR) + word_idx;
            memData  <= wbuf | (DATA_W'(rxData) << {byte_idx, 3'b000});
            memBe    <= wbe | (LANES'(1) << byte_idx);
            word_idx <= word_idx + ADDR_W'(1);
            wbuf     <= '0;
            wbe      <= '0;
            byte_idx <= '0;
          end else begin
            wbuf[{byte_idx, 3'b000} +: 8] <= rxData;
            wbe[byte_idx] <= 1'b1;
            byte_idx      <= byte_idx + LW'(1);
          end
        end
        default: ;
      endcase
    end
  end

endmodule

// File: tb/tb_prog_loader.sv
module tb_prog_loader;
  localparam int DW   = 32;
  localparam int AW   = 16;
  localparam int MW   = 4;
  localparam int BASE = 8;
  localparam int LN   = DW / 8;
  localparam int MAXB = MW * LN;

  logic          clk = 1'b0;
  logic          rst;
  logic          progEn;
  logic          rxFfEmpty = 1'b1;
  logic          rxRdEn;
  logic [7:0]    rxData = 8'h00;
  logic          memWrEn;
  logic [AW-1:0] memAddr;
  logic [DW-1:0] memData;
  logic [LN-1:0] memBe;
  logic          progBusy, progDone, progErr;

  prog_loader #(.DATA_W(DW), .ADDR_W(AW), .MEM_WORDS(MW), .BASE_ADDR(BASE)) dut (
    .clk(clk), .rst(rst), .progEn(progEn), .rxFfEmpty(rxFfEmpty), .rxRdEn(rxRdEn),
    .rxData(rxData), .memWrEn(memWrEn), .memAddr(memAddr), .memData(memData),
    .memBe(memBe), .progBusy(progBusy), .progDone(progDone), .progErr(progErr)
  );

  always #5 clk = ~clk;

  int n_assert = 0;
  int n_fail   = 0;

  // FIFO model: pop at the edge, data visible the next cycle.
  logic [7:0] fifo_q[$];
  bit  gap_en = 1'b0;
  int  n_pop = 0;
  int  n_rd_empty = 0;

  always @(posedge clk) begin
    if (rxRdEn && fifo_q.size() > 0) begin
      rxData <= fifo_q.pop_front();
      n_pop++;
    end
    #1;
    rxFfEmpty = (fifo_q.size() == 0) || (gap_en && $urandom_range(0, 2) == 0);
  end

  logic [AW-1:0] w_addr[$];
  logic [DW-1:0] w_data[$];
  logic [LN-1:0] w_be[$];

  always @(negedge clk) begin
    if (rxRdEn && rxFfEmpty) n_rd_empty++;
    if (memWrEn) begin
      w_addr.push_back(memAddr);
      w_data.push_back(memData);
      w_be.push_back(memBe);
    end
  end

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_assert++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // mode: 0 random payload, 1 nominal 11..66 payload
  task automatic run_frame(input int len, input bit bad, input bit gaps, input bit fixed);
    logic [7:0] pl[$];
    logic [7:0] cs;
    logic [31:0] l32;
    logic [DW-1:0] ed;
    logic [LN-1:0] eb;
    int nw, base_pop, base_viol, cyc, idx;
    bit exp_err;
    l32 = len;
    pl.delete();
    for (int i = 0; i < len && len <= MAXB; i++)
      pl.push_back(fixed ? 8'((i + 1) * 8'h11) : 8'($urandom_range(0, 255)));
    cs = l32[7:0] ^ l32[15:8] ^ l32[23:16] ^ l32[31:24];
    foreach (pl[i]) cs ^= pl[i];
    if (bad) cs ^= 8'h01;
    for (int i = 0; i < 4; i++) fifo_q.push_back(l32[8*i +: 8]);
    if (len > MAXB) begin
      for (int i = 0; i < 8; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
    end else begin
      foreach (pl[i]) fifo_q.push_back(pl[i]);
      fifo_q.push_back(cs);
    end
    exp_err = (len > MAXB) || bad;
    nw = (len > MAXB) ? 0 : (len + LN - 1) / LN;
    w_addr.delete(); w_data.delete(); w_be.delete();
    base_pop = n_pop;
    base_viol = n_rd_empty;
    gap_en = gaps;
    @(negedge clk) progEn = 1'b1;
    cyc = 0;
    while (!(progDone || progErr) && cyc < 2000) begin
      @(negedge clk);
      cyc++;
    end
    repeat (4) @(negedge clk);
    chk("progDone", progDone, !exp_err);
    chk("progErr", progErr, exp_err);
    chk("nwrites", w_addr.size(), nw);
    for (int w = 0; w < nw && w < w_addr.size(); w++) begin
      ed = '0; eb = '0;
      for (int k = 0; k < LN; k++) begin
        idx = w * LN + k;
        if (idx < len) begin
          ed[8*k +: 8] = pl[idx];
          eb[k] = 1'b1;
        end
      end
      chk("memAddr", w_addr[w], BASE + w);
      chk("memData", w_data[w], ed);
      chk("memBe", w_be[w], eb);
    end
    chk("nreads", n_pop - base_pop, (len > MAXB) ? 4 : len + 5);
    chk("rd_while_empty", n_rd_empty - base_viol, 0);
    progEn = 1'b0;
    gap_en = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_busy", progBusy, 0);
    chk("idle_done", progDone, 0);
    chk("idle_err", progErr, 0);
    fifo_q.delete();
    repeat (2) @(negedge clk);
  endtask

  initial begin
    int cyc, base_pop;
    rst = 1'b1;
    progEn = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_wren", memWrEn, 0);
    chk("rst_addr", memAddr, 0);
    chk("rst_busy", progBusy, 0);
    chk("rst_rden", rxRdEn, 0);
    rst = 1'b0;
    repeat (2) @(negedge clk);

    // nominal frame, checksum 0x71
    run_frame(6, 1'b0, 1'b0, 1'b1);
    // wrong checksum
    run_frame(6, 1'b1, 1'b0, 1'b1);
    // zero length
    run_frame(0, 1'b0, 1'b0, 1'b0);
    // overflow and exact-capacity boundaries
    run_frame(MAXB + 1, 1'b0, 1'b0, 1'b0);
    run_frame(MAXB, 1'b0, 1'b0, 1'b0);
    // nominal with random FIFO gaps
    run_frame(6, 1'b0, 1'b1, 1'b1);
    // random lengths with gaps
    for (int t = 0; t < 6; t++)
      run_frame($urandom_range(1, MAXB), ($urandom_range(0, 3) == 0), 1'b1, 1'b0);

    // abort after payload byte 3 is on rxData
    w_addr.delete(); w_data.delete(); w_be.delete();
    for (int i = 0; i < 4; i++) fifo_q.push_back(i == 0 ? 8'h06 : 8'h00);
    for (int i = 1; i <= 6; i++) fifo_q.push_back(8'(i * 8'h11));
    fifo_q.push_back(8'h71);
    base_pop = n_pop;
    @(negedge clk) progEn = 1'b1;
    cyc = 0;
    while (n_pop - base_pop < 7 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("abort_reached", n_pop - base_pop, 7);
    progEn = 1'b0;
    #1;
    chk("abort_rden", rxRdEn, 0);
    @(negedge clk);
    chk("abort_busy", progBusy, 0);
    chk("abort_writes", w_addr.size(), 0);
    fifo_q.delete();
    repeat (2) @(negedge clk);
    // restart begins again at BASE_ADDR
    run_frame(6, 1'b0, 1'b0, 1'b1);

    // reset mid-DATA
    for (int i = 0; i < 4; i++) fifo_q.push_back(i == 0 ? 8'd12 : 8'h00);
    for (int i = 0; i < 13; i++) fifo_q.push_back(8'($urandom_range(0, 255)));
    base_pop = n_pop;
    @(negedge clk) progEn = 1'b1;
    cyc = 0;
    while (n_pop - base_pop < 10 && cyc < 200) begin
      @(negedge clk);
      cyc++;
    end
    chk("mid_busy", progBusy, 1);
    rst = 1'b1;
    #1;
    chk("arst_wren", memWrEn, 0);
    chk("arst_addr", memAddr, 0);
    chk("arst_data", memData, 0);
    chk("arst_be", memBe, 0);
    chk("arst_busy", progBusy, 0);
    chk("arst_rden", rxRdEn, 0);
    progEn = 1'b0;
    @(negedge clk);
    rst = 1'b0;
    fifo_q.delete();
    repeat (2) @(negedge clk);
    run_frame(6, 1'b0, 1'b0, 1'b1);

    $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
    $finish;
  end
endmodule
